// File: rtl/gc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : gc_input_conditioner
// Description : Turns decoded GameCube controller state into clean game-input
//               events. A coherent snapshot of {buttons, stick} is taken once
//               per poll period, but only after the inputs have been stable for
//               QUIET_CYCLES. Each snapshot yields held levels, one-cycle
//               press/release pulses, stick directions with hysteresis, and
//               auto-repeating navigation pulses.
// Ports       : clk          - system clock
//               reset        - synchronous, active-high reset
//               btn_in[11:0] - A,B,X,Y,start,L,R,Z,D_UP,D_DOWN,D_RIGHT,D_LEFT
//               joy_x/joy_y  - main stick, unsigned, centre 128
//               frame_valid  - one-cycle pulse per new snapshot
//               btn_held     - snapshot button levels
//               btn_press    - 0->1 pulses between snapshots
//               btn_release  - 1->0 pulses between snapshots
//               dir_held     - stick directions [0]up [1]down [2]left [3]right
//               nav_pulse    - navigation events with auto-repeat
// Revision    : 1.0 - initial release
// ============================================================================
module gc_input_conditioner #(
    parameter int SAMPLE_PERIOD = 1_000_000,
    parameter int QUIET_CYCLES  = 50_000,
    parameter int DZ_ON         = 48,
    parameter int DZ_OFF        = 32,
    parameter int REPEAT_DELAY  = 40,
    parameter int REPEAT_RATE   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] btn_in,
    input  logic [7:0]  joy_x,
    input  logic [7:0]  joy_y,
    output logic        frame_valid,
    output logic [11:0] btn_held,
    output logic [11:0] btn_press,
    output logic [11:0] btn_release,
    output logic [3:0]  dir_held,
    output logic [3:0]  nav_pulse
);

    localparam int c_TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_QC_W  = (QUIET_CYCLES > 0) ? $clog2(QUIET_CYCLES + 1) : 1;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_QC_W-1:0]  c_QC_FULL   = c_QC_W'(QUIET_CYCLES);
    localparam logic [c_QC_W-1:0]  c_QC_ONE    = c_QC_W'(1);
    localparam logic signed [9:0]  c_DZ_ON     = 10'(DZ_ON);
    localparam logic signed [9:0]  c_DZ_OFF    = 10'(DZ_OFF);
    localparam logic [7:0]         c_RPT_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0]         c_RPT_RELD  = 8'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [27:0]         r_in_prev;
    logic [27:0]         w_in_cur;
    logic [c_QC_W-1:0]   r_quiet;
    logic                w_quiet_full;
    logic [c_TMR_W-1:0]  r_timer;
    logic                w_wrap;

    logic signed [9:0]   w_ox;
    logic signed [9:0]   w_nx;
    logic signed [9:0]   w_oy;
    logic signed [9:0]   w_ny;
    logic [3:0]          w_dir_next;

    logic [3:0]          w_nav_active;
    logic [3:0]          r_nav_active;
    logic [3:0][7:0]     r_rpt_cnt;
    logic [3:0][7:0]     w_rpt_inc;

    assign w_in_cur     = {btn_in, joy_x, joy_y};
    assign w_quiet_full = (r_quiet == c_QC_FULL);
    assign w_wrap       = (r_timer == c_TMR_LAST);

    // ------------------------------------------------------------------
    // Change detection, sample timer and snapshot state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_prev <= '0;
            r_quiet   <= '0;
            r_timer   <= '0;
            r_state   <= S_IDLE;
        end else begin
            r_in_prev <= w_in_cur;
            if (w_in_cur != r_in_prev) begin
                r_quiet <= '0;
            end else if (!w_quiet_full) begin
                r_quiet <= r_quiet + c_QC_ONE;
            end
            r_timer <= w_wrap ? '0 : (r_timer + c_TMR_ONE);
            r_state <= w_state_next;
        end
    end

    // A wrap seen while already pending is absorbed; a wrap during the
    // capture cycle re-arms the request so no poll period is lost.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_wrap) w_state_next = S_PENDING;
            S_PENDING: if (w_quiet_full) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = w_wrap ? S_PENDING : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stick offsets and hysteresis (10-bit signed so -(-128) is exact)
    // ------------------------------------------------------------------
    assign w_ox = $signed({2'b00, joy_x}) - 10'sd128;
    assign w_oy = $signed({2'b00, joy_y}) - 10'sd128;
    assign w_nx = -w_ox;
    assign w_ny = -w_oy;

    always_comb begin
        w_dir_next    = '0;
        w_dir_next[0] = dir_held[0] ? (w_oy >= c_DZ_OFF) : (w_oy >= c_DZ_ON);
        w_dir_next[1] = dir_held[1] ? (w_ny >= c_DZ_OFF) : (w_ny >= c_DZ_ON);
        w_dir_next[2] = dir_held[2] ? (w_nx >= c_DZ_OFF) : (w_nx >= c_DZ_ON);
        w_dir_next[3] = dir_held[3] ? (w_ox >= c_DZ_OFF) : (w_ox >= c_DZ_ON);
    end

    // ------------------------------------------------------------------
    // Snapshot registers and edge pulses; btn_held doubles as the
    // previous snapshot for edge detection.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            btn_held    <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            dir_held    <= '0;
        end else begin
            frame_valid <= 1'b0;
            btn_press   <= '0;
            btn_release <= '0;
            if (r_state == S_CAPTURE) begin
                frame_valid <= 1'b1;
                btn_held    <= btn_in;
                btn_press   <= btn_in & ~btn_held;
                btn_release <= ~btn_in & btn_held;
                dir_held    <= w_dir_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Navigation with auto-repeat, evaluated on the cycle frame_valid is
    // high so it sees the freshly updated dir_held / btn_held.
    // Lane order: up=D_UP(8), down=D_DOWN(9), left=D_LEFT(11), right=D_RIGHT(10)
    // ------------------------------------------------------------------
    assign w_nav_active = dir_held | {btn_held[10], btn_held[11], btn_held[9], btn_held[8]};

    always_comb begin
        w_rpt_inc = '0;
        for (int d = 0; d < 4; d++) begin
            w_rpt_inc[d] = r_rpt_cnt[d] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nav_active <= '0;
            r_rpt_cnt    <= '0;
            nav_pulse    <= '0;
        end else begin
            nav_pulse <= '0;
            if (frame_valid) begin
                r_nav_active <= w_nav_active;
                for (int d = 0; d < 4; d++) begin
                    if (!w_nav_active[d]) begin
                        r_rpt_cnt[d] <= '0;
                    end else if (!r_nav_active[d]) begin
                        nav_pulse[d] <= 1'b1;
                        r_rpt_cnt[d] <= '0;
                    end else if (w_rpt_inc[d] == c_RPT_DELAY) begin
                        // Reload below the threshold so later repeats land
                        // every REPEAT_RATE snapshots without the counter wrapping.
                        nav_pulse[d] <= 1'b1;
                        r_rpt_cnt[d] <= c_RPT_RELD;
                    end else begin
                        r_rpt_cnt[d] <= w_rpt_inc[d];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gc_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_gc_input_conditioner
// Description : Self-checking bench for gc_input_conditioner. A reference model
//               predicts when snapshots occur and what they contain; expected
//               frames and navigation pulses are queued and a separate monitor
//               compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gc_input_conditioner;

    localparam int P     = 100;
    localparam int Q     = 20;
    localparam int DON   = 48;
    localparam int DOFF  = 32;
    localparam int DELAY = 4;
    localparam int RATE  = 2;

    logic        clk;
    logic        reset;
    logic [11:0] btn_in;
    logic [7:0]  joy_x;
    logic [7:0]  joy_y;
    logic        frame_valid;
    logic [11:0] btn_held;
    logic [11:0] btn_press;
    logic [11:0] btn_release;
    logic [3:0]  dir_held;
    logic [3:0]  nav_pulse;

    gc_input_conditioner #(
        .SAMPLE_PERIOD (P),
        .QUIET_CYCLES  (Q),
        .DZ_ON         (DON),
        .DZ_OFF        (DOFF),
        .REPEAT_DELAY  (DELAY),
        .REPEAT_RATE   (RATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .joy_x       (joy_x),
        .joy_y       (joy_y),
        .frame_valid (frame_valid),
        .btn_held    (btn_held),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .dir_held    (dir_held),
        .nav_pulse   (nav_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] held;
        logic [11:0] press;
        logic [11:0] rel;
        logic [3:0]  dir;
    } frame_t;

    typedef struct {
        int         cyc;
        logic [3:0] nav;
    } nav_t;

    frame_t fq[$];
    nav_t   nq[$];

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          m_k;          // cycles since reset release
    int          m_eq_run;     // consecutive cycles the inputs matched the cycle before
    bit          m_pend;       // a poll request is outstanding
    bit          m_cap_next;   // snapshot is taken on the next cycle
    logic [27:0] m_prev;
    logic [11:0] m_snap;
    logic [3:0]  m_dir;
    int          m_run[4];     // consecutive active snapshots per direction
    int          m_caps;

    logic [11:0] cur_b;
    logic [7:0]  cur_x, cur_y;

    logic [7:0] joy_tbl [12] = '{8'd128, 8'd0, 8'd255, 8'd176, 8'd175, 8'd160,
                                 8'd159, 8'd80, 8'd81, 8'd96, 8'd97, 8'd200};

    function automatic bit hyst(input bit prev, input int off);
        return prev ? (off >= DOFF) : (off >= DON);
    endfunction

    task automatic model_reset(input int t);
        m_k = 0; m_eq_run = 0; m_pend = 0; m_cap_next = 0;
        m_prev = '0; m_snap = '0; m_dir = '0;
        for (int d = 0; d < 4; d++) m_run[d] = 0;
        while (fq.size() > 0 && fq[$].cyc > t) void'(fq.pop_back());
        while (nq.size() > 0 && nq[$].cyc > t) void'(nq.pop_back());
    endtask

    task automatic model_snapshot(input int t, input logic [11:0] b,
                                  input logic [7:0] x, input logic [7:0] y);
        frame_t     f;
        nav_t       n;
        logic [3:0] nd;
        logic [3:0] dpad;
        int         ox, oy;
        ox = int'(x) - 128;
        oy = int'(y) - 128;
        nd[0] = hyst(m_dir[0], oy);
        nd[1] = hyst(m_dir[1], -oy);
        nd[2] = hyst(m_dir[2], -ox);
        nd[3] = hyst(m_dir[3], ox);
        f.cyc = t + 1; f.held = b; f.press = b & ~m_snap; f.rel = ~b & m_snap; f.dir = nd;
        fq.push_back(f);
        m_snap = b;
        m_dir  = nd;
        m_caps++;
        dpad = {b[10], b[11], b[9], b[8]};
        n.cyc = t + 2;
        n.nav = '0;
        for (int d = 0; d < 4; d++) begin
            if (nd[d] || dpad[d]) begin
                m_run[d]++;
                if (m_run[d] == 1 || (m_run[d] > DELAY && (m_run[d] - 1 - DELAY) % RATE == 0))
                    n.nav[d] = 1'b1;
            end else begin
                m_run[d] = 0;
            end
        end
        if (n.nav != 0) nq.push_back(n);
    endtask

    task automatic model_cycle(input int t);
        bit          cap_now;
        logic [27:0] in_now;
        in_now     = {btn_in, joy_x, joy_y};
        cap_now    = m_cap_next;
        m_cap_next = 0;
        if (m_pend && m_eq_run >= Q) begin
            m_cap_next = 1;
            m_pend     = 0;
        end else if (m_k % P == P - 1) begin
            m_pend = 1;
        end
        m_eq_run = (in_now == m_prev) ? m_eq_run + 1 : 0;
        m_prev   = in_now;
        m_k++;
        if (cap_now) model_snapshot(t, btn_in, joy_x, joy_y);
    endtask

    // Apply one cycle of stimulus just after the rising edge.
    task automatic drive(input logic [11:0] b, input logic [7:0] x,
                         input logic [7:0] y, input logic rst);
        @(posedge clk);
        #1;
        btn_in = b; joy_x = x; joy_y = y; reset = rst;
        cur_b = b; cur_x = x; cur_y = y;
        if (rst) model_reset(cyc);
        else     model_cycle(cyc);
    endtask

    task automatic hold(input logic [11:0] b, input logic [7:0] x,
                        input logic [7:0] y, input int n);
        for (int i = 0; i < n; i++) drive(b, x, y, 1'b0);
    endtask

    task automatic do_reset(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y);
        drive(b, x, y, 1'b1);
        drive(b, x, y, 1'b1);
        drive(b, x, y, 1'b0);
        @(negedge clk);
        n_vec++;
        if ({frame_valid, btn_held, btn_press, btn_release, dir_held, nav_pulse} !== '0) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d fv=%b held=%h press=%h rel=%h dir=%h nav=%h required all 0",
                     cyc, frame_valid, btn_held, btn_press, btn_release, dir_held, nav_pulse);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        frame_t e;
        nav_t   n;
        if (frame_valid) begin
            n_vec++;
            if (fq.size() == 0) begin
                n_err++;
                $display("FAIL frame_unexpected cyc=%0d held=%h press=%h rel=%h required no frame",
                         cyc, btn_held, btn_press, btn_release);
            end else begin
                e = fq.pop_front();
                if (e.cyc != cyc || btn_held !== e.held || btn_press !== e.press ||
                    btn_release !== e.rel || dir_held !== e.dir) begin
                    n_err++;
                    $display("FAIL frame cyc=%0d/%0d held=%h/%h press=%h/%h rel=%h/%h dir=%h/%h (actual/required)",
                             cyc, e.cyc, btn_held, e.held, btn_press, e.press,
                             btn_release, e.rel, dir_held, e.dir);
                end
            end
        end else begin
            n_vec++;
            if ((btn_press | btn_release) !== 12'h000) begin
                n_err++;
                $display("FAIL pulse_outside_frame cyc=%0d press=%h rel=%h required 0",
                         cyc, btn_press, btn_release);
            end
        end
        while (fq.size() > 0 && fq[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_missing cyc=%0d actual none required frame at cyc %0d held=%h",
                     cyc, fq[0].cyc, fq[0].held);
            void'(fq.pop_front());
        end
        if (nav_pulse !== 4'h0) begin
            n_vec++;
            if (nq.size() == 0) begin
                n_err++;
                $display("FAIL nav_unexpected cyc=%0d nav=%h required 0", cyc, nav_pulse);
            end else begin
                n = nq.pop_front();
                if (n.cyc != cyc || nav_pulse !== n.nav) begin
                    n_err++;
                    $display("FAIL nav cyc=%0d/%0d nav=%h/%h (actual/required)",
                             cyc, n.cyc, nav_pulse, n.nav);
                end
            end
        end
        while (nq.size() > 0 && nq[0].cyc < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL nav_missing cyc=%0d actual 0 required %h at cyc %0d",
                     cyc, nq[0].nav, nq[0].cyc);
            void'(nq.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int caps0;
        reset = 1'b1; btn_in = '0; joy_x = 8'd128; joy_y = 8'd128;
        cur_b = '0; cur_x = 8'd128; cur_y = 8'd128;
        m_caps = 0;
        model_reset(0);

        // Power-on: one held button, stick centred
        do_reset(12'h001, 8'd128, 8'd128);
        hold(12'h001, 8'd128, 8'd128, 150);

        // Inputs that never settle, then settle on start_pause
        for (int i = 0; i < 30; i++) hold((i % 2) ? 12'h020 : 12'h040, 8'd128, 8'd128, 10);
        hold(12'h010, 8'd128, 8'd128, 200);

        // Right-direction hysteresis around the thresholds
        hold(12'h000, 8'd176, 8'd128, 100);
        hold(12'h000, 8'd170, 8'd128, 100);
        hold(12'h000, 8'd159, 8'd128, 100);
        hold(12'h000, 8'd160, 8'd128, 100);

        // Stick up held for many snapshots, then released
        hold(12'h000, 8'd128, 8'd255, 1000);
        hold(12'h000, 8'd128, 8'd128, 300);

        // D_UP hold handing over to the stick without a gap in activity
        hold(12'h100, 8'd128, 8'd128, 500);
        hold(12'h000, 8'd128, 8'd200, 400);
        hold(12'h000, 8'd128, 8'd128, 200);

        // Reset while a snapshot request is outstanding
        hold(12'h003, 8'd128, 8'd128, 150);
        caps0 = m_caps;
        for (int i = 0; i < 400 && m_caps == caps0; i++) drive(12'h000, 8'd128, 8'd128, 1'b0);
        for (int i = 0; i < 400 && !m_pend; i++) drive(12'h000, 8'd128, 8'd128, 1'b0);
        n_vec++;
        if (m_caps == caps0 || !m_pend) begin
            n_err++;
            $display("FAIL pending_reach cyc=%0d caps=%0d pend=%0d required capture then pending",
                     cyc, m_caps - caps0, m_pend);
        end
        do_reset(12'h000, 8'd128, 8'd128);
        hold(12'h000, 8'd128, 8'd128, 250);

        // Randomized segments over buttons and boundary stick values
        for (int s = 0; s < 60; s++) begin
            logic [11:0] b;
            b = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            hold(b, joy_tbl[$urandom_range(0, 11)], joy_tbl[$urandom_range(0, 11)],
                 $urandom_range(1, 140));
        end

        // Drain outstanding expectations with a bounded wait
        for (int i = 0; i < 300 && (fq.size() > 0 || nq.size() > 0); i++)
            drive(cur_b, cur_x, cur_y, 1'b0);
        n_vec++;
        if (fq.size() != 0 || nq.size() != 0) begin
            n_err++;
            $display("FAIL drain frames=%0d navs=%0d required 0 outstanding", fq.size(), nq.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
